// File: rtl/d_stim_sequencer_pkg.sv
// Shared definitions for the D flip-flop stimulus sequencer: FSM encoding and
// the default segment table (level/duration pairs, 500 cycles in total).
package d_stim_sequencer_pkg;

    localparam int DEF_NUM_SEG = 9;
    localparam int DEF_DUR_W   = 8;
    localparam int DEF_IDX_W   = 4;

    // Entry i lives at bit i of the level table and bits [i*8 +: 8] of the duration table.
    localparam logic [8:0]  DEF_LVL_TABLE = 9'b1_0101_0101;
    localparam logic [71:0] DEF_DUR_TABLE = {8'd60, 8'd70, 8'd20, 8'd100, 8'd50,
                                             8'd60, 8'd15, 8'd75, 8'd50};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/d_stim_rom.sv
// Combinational segment table: index -> {level, duration}. A zero duration is
// promoted to one cycle so the sequencer never sees a zero-length segment.
module d_stim_rom
    import d_stim_sequencer_pkg::*;
#(
    parameter int                        NUM_SEG   = DEF_NUM_SEG,
    parameter int                        DUR_W     = DEF_DUR_W,
    parameter int                        IDX_W     = DEF_IDX_W,
    parameter logic [NUM_SEG-1:0]        LVL_TABLE = DEF_LVL_TABLE,
    parameter logic [NUM_SEG*DUR_W-1:0]  DUR_TABLE = DEF_DUR_TABLE
) (
    input  logic [IDX_W-1:0] seg_idx,
    output logic             lvl,
    output logic [DUR_W-1:0] dur
);

    logic [DUR_W-1:0] raw_dur;

    always_comb begin
        lvl     = 1'b0;
        raw_dur = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (seg_idx == IDX_W'(i)) begin
                lvl     = LVL_TABLE[i];
                raw_dur = DUR_TABLE[i*DUR_W +: DUR_W];
            end
        end
    end

    assign dur = (raw_dur == '0) ? DUR_W'(1) : raw_dur;

endmodule

// File: rtl/d_stim_sequencer.sv
// Replays the segment table onto D_out, one level per segment for its duration
// in clkin cycles, with optional looping, abort and a one-cycle done pulse.
module d_stim_sequencer
    import d_stim_sequencer_pkg::*;
#(
    parameter int                        NUM_SEG    = DEF_NUM_SEG,
    parameter int                        DUR_W      = DEF_DUR_W,
    parameter int                        IDX_W      = DEF_IDX_W,
    parameter logic                      IDLE_LEVEL = 1'b0,
    parameter logic [NUM_SEG-1:0]        LVL_TABLE  = DEF_LVL_TABLE,
    parameter logic [NUM_SEG*DUR_W-1:0]  DUR_TABLE  = DEF_DUR_TABLE
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             loop_en,
    output logic             D_out,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] seg_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] seg_n, rom_idx;
    logic [DUR_W-1:0] cnt, cnt_n, rom_dur;
    logic             rom_lvl, d_n, busy_n, done_n;

    // The ROM is always addressed with the segment about to be loaded, so one
    // table lookup serves both run start (index 0) and segment advance.
    always_comb begin
        rom_idx = '0;
        if (state == ST_RUN && cnt == '0 && seg_idx != LAST_IDX)
            rom_idx = seg_idx + 1'b1;
    end

    d_stim_rom #(
        .NUM_SEG   (NUM_SEG),
        .DUR_W     (DUR_W),
        .IDX_W     (IDX_W),
        .LVL_TABLE (LVL_TABLE),
        .DUR_TABLE (DUR_TABLE)
    ) u_rom (
        .seg_idx (rom_idx),
        .lvl     (rom_lvl),
        .dur     (rom_dur)
    );

    always_comb begin
        state_n = state;
        seg_n   = seg_idx;
        cnt_n   = cnt;
        d_n     = D_out;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                    seg_n   = '0;
                    d_n     = rom_lvl;
                    cnt_n   = rom_dur - 1'b1;
                    busy_n  = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    seg_n   = '0;
                    cnt_n   = '0;
                    d_n     = IDLE_LEVEL;
                    busy_n  = 1'b0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (seg_idx != LAST_IDX || loop_en) begin
                    seg_n = rom_idx;
                    d_n   = rom_lvl;
                    cnt_n = rom_dur - 1'b1;
                end else begin
                    state_n = ST_FIN;
                    seg_n   = '0;
                    d_n     = IDLE_LEVEL;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                seg_n   = '0;
                cnt_n   = '0;
                d_n     = IDLE_LEVEL;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            seg_idx <= '0;
            cnt     <= '0;
            D_out   <= IDLE_LEVEL;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            seg_idx <= seg_n;
            cnt     <= cnt_n;
            D_out   <= d_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_d_stim_sequencer.sv
// Self-checking bench for d_stim_sequencer: full-table replay, looping, abort,
// async reset, and back-to-back runs on a small table containing a zero duration.
module tb_d_stim_sequencer;

    typedef struct packed {
        logic       d;
        logic       busy;
        logic       done;
        logic [3:0] seg;
    } exp_t;

    typedef struct {
        bit   start;
        bit   abort;
        exp_t exp;
    } vec_t;

    logic       clkin   = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic       loop_en = 1'b0;
    logic       d_out, busy, done;
    logic [3:0] seg_idx;

    logic       start2 = 1'b0;
    logic       abort2 = 1'b0;
    logic       d_out2, busy2, done2;
    logic [3:0] seg_idx2;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Segment start offsets (cycles after the start edge) and levels of the default table.
    int seg_start[10] = '{0, 50, 125, 140, 200, 250, 350, 370, 440, 500};
    bit seg_lvl[9]    = '{1, 0, 1, 0, 1, 0, 1, 0, 1};

    always #5 clkin = ~clkin;

    d_stim_sequencer dut (
        .clkin   (clkin),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .loop_en (loop_en),
        .D_out   (d_out),
        .busy    (busy),
        .done    (done),
        .seg_idx (seg_idx)
    );

    // Three segments: 1 for 3 cycles, 0 for a zero-duration entry, 1 for 2 cycles.
    d_stim_sequencer #(
        .NUM_SEG   (3),
        .LVL_TABLE (3'b101),
        .DUR_TABLE ({8'd2, 8'd0, 8'd3})
    ) dut2 (
        .clkin   (clkin),
        .rst_n   (rst_n),
        .start   (start2),
        .abort   (abort2),
        .loop_en (1'b0),
        .D_out   (d_out2),
        .busy    (busy2),
        .done    (done2),
        .seg_idx (seg_idx2)
    );

    function automatic exp_t expAt(input int off, input bit looping);
        exp_t e;
        int   o;
        e = '0;
        o = looping ? off % 500 : off;
        if (looping || off < 500) begin
            for (int s = 0; s < 9; s++) begin
                if (o >= seg_start[s] && o < seg_start[s+1]) begin
                    e.d   = seg_lvl[s];
                    e.seg = 4'(s);
                end
            end
            e.busy = 1'b1;
        end else if (off == 500) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input exp_t e, input logic d,
                               input logic b, input logic dn, input logic [3:0] s);
        checks++;
        if (d !== e.d || b !== e.busy || dn !== e.done || s !== e.seg) begin
            errors++;
            $display("[TB] FAIL %s: got d=%b busy=%b done=%b seg=%0d, expected d=%b busy=%b done=%b seg=%0d",
                     name, d, b, dn, s, e.d, e.busy, e.done, e.seg);
        end
    endtask

    task automatic applyStimulus(input bit st, input bit ab, input bit lp);
        start   = st;
        abort   = ab;
        loop_en = lp;
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    // Caller raises start before calling; the first edge inside is offset 0.
    task automatic runSeq(input string name, input int n, input bit looping);
        exp_t e;
        for (int off = 0; off < n; off++) begin
            sb.push_back(expAt(off, looping));
            tick();
            if (off == 0) start = 1'b0;
            e = sb.pop_front();
            checkOutput($sformatf("%s@%0d", name, off), e, d_out, busy, done, seg_idx);
        end
    endtask

    initial begin
        vec_t vecs[15];
        exp_t e;

        vecs[0]  = '{1'b1, 1'b0, exp_t'({1'b1, 1'b1, 1'b0, 4'd0})};
        vecs[1]  = '{1'b1, 1'b0, exp_t'({1'b1, 1'b1, 1'b0, 4'd0})};
        vecs[2]  = '{1'b1, 1'b0, exp_t'({1'b1, 1'b1, 1'b0, 4'd0})};
        vecs[3]  = '{1'b1, 1'b0, exp_t'({1'b0, 1'b1, 1'b0, 4'd1})};
        vecs[4]  = '{1'b1, 1'b0, exp_t'({1'b1, 1'b1, 1'b0, 4'd2})};
        vecs[5]  = '{1'b1, 1'b0, exp_t'({1'b1, 1'b1, 1'b0, 4'd2})};
        vecs[6]  = '{1'b1, 1'b0, exp_t'({1'b0, 1'b0, 1'b1, 4'd0})};
        vecs[7]  = '{1'b1, 1'b0, exp_t'({1'b0, 1'b0, 1'b0, 4'd0})};
        vecs[8]  = '{1'b1, 1'b0, exp_t'({1'b1, 1'b1, 1'b0, 4'd0})};
        vecs[9]  = '{1'b1, 1'b0, exp_t'({1'b1, 1'b1, 1'b0, 4'd0})};
        vecs[10] = '{1'b1, 1'b0, exp_t'({1'b1, 1'b1, 1'b0, 4'd0})};
        vecs[11] = '{1'b1, 1'b0, exp_t'({1'b0, 1'b1, 1'b0, 4'd1})};
        vecs[12] = '{1'b1, 1'b1, exp_t'({1'b0, 1'b0, 1'b0, 4'd0})};
        vecs[13] = '{1'b1, 1'b0, exp_t'({1'b1, 1'b1, 1'b0, 4'd0})};
        vecs[14] = '{1'b0, 1'b1, exp_t'({1'b0, 1'b0, 1'b0, 4'd0})};

        // Reset held, then released with no start.
        repeat (3) tick();
        checkOutput("reset_held", '0, d_out, busy, done, seg_idx);
        checkOutput("reset_held2", '0, d_out2, busy2, done2, seg_idx2);
        @(negedge clkin);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput($sformatf("idle@%0d", i), '0, d_out, busy, done, seg_idx);
        end

        $display("[TB] single run, loop disabled");
        applyStimulus(1'b1, 1'b0, 1'b0);
        runSeq("run", 503, 1'b0);

        $display("[TB] looping run, two passes");
        applyStimulus(1'b1, 1'b0, 1'b1);
        runSeq("loop", 1001, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("loop_abort", '0, d_out, busy, done, seg_idx);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] abort in segment 2");
        applyStimulus(1'b1, 1'b0, 1'b0);
        runSeq("pre_abort", 131, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort", '0, d_out, busy, done, seg_idx);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("post_abort@%0d", i), '0, d_out, busy, done, seg_idx);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        runSeq("replay", 60, 1'b0);

        $display("[TB] asynchronous reset mid-run");
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        runSeq("pre_reset", 261, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", '0, d_out, busy, done, seg_idx);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("in_reset@%0d", i), '0, d_out, busy, done, seg_idx);
        end
        rst_n = 1'b1;
        tick();
        checkOutput("after_reset", '0, d_out, busy, done, seg_idx);
        applyStimulus(1'b1, 1'b0, 1'b0);
        runSeq("restart", 60, 1'b0);

        $display("[TB] back-to-back runs with zero-duration entry");
        for (int i = 0; i < 15; i++) begin
            start2 = vecs[i].start;
            abort2 = vecs[i].abort;
            sb.push_back(vecs[i].exp);
            tick();
            e = sb.pop_front();
            checkOutput($sformatf("b2b@%0d", i), e, d_out2, busy2, done2, seg_idx2);
        end
        start2 = 1'b0;
        abort2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
